clint: RTL

Core-local interruptor. A Wishbone slave on the core's data bus that holds the machine software-interrupt bit, the free-running `mtime` counter and the `mtimecmp` compare register. It drives them straight into the core's `mem_msip`, `mem_mtime` and `mem_mtimecmp` inputs; the core performs the timer comparison itself. It sits downstream of the core's bus interface, behind the address decoder, and feeds the core's interrupt inputs back.

---
 rtl/clint.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/clint.sv
// ============================================================================
// Module   : clint
// Purpose  : Core-local interruptor as a Wishbone slave, holding msip, the
//            free-running mtime counter and mtimecmp. Optional feature macro:
//            CLINT_PRESCALER_EN divides the mtime tick by PRESCALE.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clint #(
  parameter int DATA_SIZE = 32,
  parameter int PRESCALE  = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   CYC_I,
  input  logic                   STB_I,
  input  logic                   WE_I,
  input  logic [DATA_SIZE/8-1:0] SEL_I,
  input  logic [15:0]            ADR_I,
  input  logic [DATA_SIZE-1:0]   DAT_I,
  output logic [DATA_SIZE-1:0]   DAT_O,
  output logic                   ACK_O,
  output logic [DATA_SIZE-1:0]   msip,
  output logic [63:0]            mtime,
  output logic [63:0]            mtimecmp
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_t;

  state_t r_state;

  logic        r_msip;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;

  logic                 w_accept;
  logic                 w_wr;
  logic                 w_tick;
  logic                 w_hit_msip;
  logic                 w_hit_tim;
  logic [7:0]           w_be_cmp;
  logic [7:0]           w_be_tim;
  logic [63:0]          w_wdata;
  logic [DATA_SIZE-1:0] w_rdata;

  assign w_accept = (r_state == S_IDLE) & CYC_I & STB_I;
  assign w_wr     = w_accept & WE_I;

  // Address decode and per-byte enables, expressed on a 64-bit register view
  generate
    if (DATA_SIZE == 64) begin : g_dec64
      logic w_hit_cmp;
      logic w_unused_adr;

      assign w_hit_msip   = (ADR_I[15:3] == 13'h0000);
      assign w_hit_cmp    = (ADR_I[15:3] == 13'h0800);
      assign w_hit_tim    = (ADR_I[15:3] == 13'h17FF);
      assign w_unused_adr = ^ADR_I[2:0];

      assign w_wdata  = DAT_I;
      assign w_be_cmp = w_hit_cmp ? SEL_I : 8'h00;
      assign w_be_tim = w_hit_tim ? SEL_I : 8'h00;

      always_comb begin
        w_rdata = '0;
        if (w_hit_msip)     w_rdata = {63'd0, r_msip};
        else if (w_hit_cmp) w_rdata = r_mtimecmp;
        else if (w_hit_tim) w_rdata = r_mtime;
      end
    end else begin : g_dec32
      logic w_hit_cmp_lo;
      logic w_hit_cmp_hi;
      logic w_hit_tim_lo;
      logic w_hit_tim_hi;
      logic w_unused_adr;

      assign w_hit_msip   = (ADR_I[15:2] == 14'h0000);
      assign w_hit_cmp_lo = (ADR_I[15:2] == 14'h1000);
      assign w_hit_cmp_hi = (ADR_I[15:2] == 14'h1001);
      assign w_hit_tim_lo = (ADR_I[15:2] == 14'h2FFE);
      assign w_hit_tim_hi = (ADR_I[15:2] == 14'h2FFF);
      assign w_hit_tim    = w_hit_tim_lo | w_hit_tim_hi;
      assign w_unused_adr = ^ADR_I[1:0];

      // Replicate the word on both halves; the byte enables pick the target half
      assign w_wdata  = {DAT_I, DAT_I};
      assign w_be_cmp = w_hit_cmp_lo ? {4'h0, SEL_I} :
                        w_hit_cmp_hi ? {SEL_I, 4'h0} : 8'h00;
      assign w_be_tim = w_hit_tim_lo ? {4'h0, SEL_I} :
                        w_hit_tim_hi ? {SEL_I, 4'h0} : 8'h00;

      always_comb begin
        w_rdata = '0;
        if (w_hit_msip)        w_rdata = {31'd0, r_msip};
        else if (w_hit_cmp_lo) w_rdata = r_mtimecmp[31:0];
        else if (w_hit_cmp_hi) w_rdata = r_mtimecmp[63:32];
        else if (w_hit_tim_lo) w_rdata = r_mtime[31:0];
        else if (w_hit_tim_hi) w_rdata = r_mtime[63:32];
      end
    end
  endgenerate

`ifdef CLINT_PRESCALER_EN
  localparam int c_PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [c_PW-1:0] r_pcnt;

  assign w_tick = (r_pcnt == c_PW'(PRESCALE - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pcnt <= '0;
    end else if (w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + c_PW'(1);
    end
  end
`else
  logic w_unused_prescale;

  assign w_tick            = 1'b1;
  assign w_unused_prescale = (PRESCALE != 0);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_msip     <= 1'b0;
      r_mtime    <= '0;
      r_mtimecmp <= '1;
    end else begin
      if (w_wr && w_hit_msip && SEL_I[0]) begin
        r_msip <= DAT_I[0];
      end
      for (int i = 0; i < 8; i++) begin
        if (w_wr && w_be_cmp[i]) r_mtimecmp[i*8 +: 8] <= w_wdata[i*8 +: 8];
      end
      // An accepted mtime write suppresses the increment for that cycle
      if (w_wr && w_hit_tim) begin
        for (int i = 0; i < 8; i++) begin
          if (w_be_tim[i]) r_mtime[i*8 +: 8] <= w_wdata[i*8 +: 8];
        end
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      ACK_O   <= 1'b0;
      DAT_O   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (CYC_I && STB_I) begin
            r_state <= S_ACK;
            ACK_O   <= 1'b1;
            DAT_O   <= WE_I ? '0 : w_rdata;
          end
        end
        default: begin
          r_state <= S_IDLE;
          ACK_O   <= 1'b0;
        end
      endcase
    end
  end

  assign msip     = {{(DATA_SIZE-1){1'b0}}, r_msip};
  assign mtime    = r_mtime;
  assign mtimecmp = r_mtimecmp;

endmodule

`default_nettype wire
